cordic_input_deserializer: RTL and testbench

- Upstream neighbour of the CORDIC test wrapper: assembles the wrapper's full-width input word (func bit plus operand data) from a narrow pin-limited lane.
- Output pair o_vld/o_data connects directly to the wrapper's i_vld/i_data. The wrapper accepts input every cycle and has no ready, so the block has no backpressure.
- Lane protocol: start-of-frame marker, gaps between beats tolerated, sticky error reporting.

---
 rtl/cordic_deser_pkg.sv | 13 +
 rtl/lane_parity_chk.sv | 12 +
 rtl/cordic_input_deserializer.sv | 107 ++++++++++
 tb/tb_cordic_input_deserializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_deser_pkg.sv
// cordic_deser_pkg: shared types and helpers for the CORDIC input deserializer.
package cordic_deser_pkg;

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam int ERR_ORPHAN  = 0;
    localparam int ERR_RESTART = 1;

    function automatic int num_beats(input int data_width, input int lane_width);
        return (data_width + lane_width - 1) / lane_width;
    endfunction

endpackage

// File: rtl/lane_parity_chk.sv
// lane_parity_chk: even-parity check of one lane beat (ok=1 when data plus parity bit has even weight).
module lane_parity_chk #(
    parameter int LANE_WIDTH = 7
) (
    input  logic [LANE_WIDTH-1:0] data,
    input  logic                  par,
    output logic                  ok
);

    assign ok = ~^{data, par};

endmodule

// File: rtl/cordic_input_deserializer.sv
// cordic_input_deserializer: assembles MSB-first lane beats into the CORDIC wrapper input word.
// Optional lane parity checking is enabled by defining CORDIC_DESER_PARITY_EN.
module cordic_input_deserializer
    import cordic_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 49,
    parameter int LANE_WIDTH = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_async_rst,
    input  logic                  i_lane_vld,
    input  logic                  i_lane_sof,
    input  logic [LANE_WIDTH-1:0] i_lane_data,
    input  logic                  i_err_clr,
`ifdef CORDIC_DESER_PARITY_EN
    input  logic                  i_lane_par,
    output logic                  o_par_err,
`endif
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic [1:0]            o_err,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt
);

    localparam int NB = num_beats(DATA_WIDTH, LANE_WIDTH);
    localparam int SW = NB * LANE_WIDTH;
    localparam int BW = $clog2(NB + 1);

    state_t          state, state_nxt;
    logic [SW-1:0]   sr, sr_nxt;
    logic [BW-1:0]   cnt, cnt_nxt;
    logic            start, push, last, done;
    logic [1:0]      err_set;

    always_comb begin
        start                = i_lane_vld && i_lane_sof;
        push                 = i_lane_vld && !i_lane_sof && state == COLLECT;
        err_set[ERR_ORPHAN]  = i_lane_vld && !i_lane_sof && state == IDLE;
        err_set[ERR_RESTART] = start && state == COLLECT;
        last                 = (start && NB == 1) || (push && cnt == BW'(NB - 1));
        sr_nxt               = start ? SW'(i_lane_data) :
                               push  ? (sr << LANE_WIDTH) | SW'(i_lane_data) : sr;
        cnt_nxt              = last  ? '0 :
                               start ? BW'(1) :
                               push  ? cnt + 1'b1 : cnt;
        state_nxt            = last ? IDLE : start ? COLLECT : state;
    end

`ifdef CORDIC_DESER_PARITY_EN
    logic par_ok, par_bad, poison, poison_nxt;

    lane_parity_chk #(.LANE_WIDTH(LANE_WIDTH)) u_par (
        .data (i_lane_data),
        .par  (i_lane_par),
        .ok   (par_ok)
    );

    assign par_bad = i_lane_vld && !par_ok;

    // A sof beat starts a fresh frame, so poison restarts from that beat alone.
    always_comb poison_nxt = start ? par_bad : push ? (poison | par_bad) : poison;

    assign done = last && !poison_nxt;

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            poison    <= 1'b0;
            o_par_err <= 1'b0;
        end else begin
            poison    <= poison_nxt;
            o_par_err <= par_bad | (o_par_err & ~i_err_clr);
        end
    end
`else
    assign done = last;
`endif

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) state <= IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            sr          <= '0;
            cnt         <= '0;
            o_vld       <= 1'b0;
            o_data      <= '0;
            o_busy      <= 1'b0;
            o_err       <= '0;
            o_frame_cnt <= '0;
        end else begin
            sr          <= sr_nxt;
            cnt         <= cnt_nxt;
            o_vld       <= done;
            o_busy      <= state_nxt == COLLECT;
            o_err       <= err_set | (o_err & ~{2{i_err_clr}});
            if (done) begin
                o_data      <= sr_nxt[DATA_WIDTH-1:0];
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_input_deserializer.sv
// tb_cordic_input_deserializer: directed and random checks against a queue-based frame model.
// Parity scenarios are exercised when CORDIC_DESER_PARITY_EN is defined.
module tb_cordic_input_deserializer;

    localparam int DW = 49;
    localparam int LW = 7;
    localparam int CW = 16;
    localparam int NB = (DW + LW - 1) / LW;

    logic          clk = 1'b0;
    logic          i_async_rst = 1'b0;
    logic          i_lane_vld = 1'b0;
    logic          i_lane_sof = 1'b0;
    logic [LW-1:0] i_lane_data = '0;
    logic          i_err_clr = 1'b0;
    logic          o_vld;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic [1:0]    o_err;
    logic [CW-1:0] o_frame_cnt;
`ifdef CORDIC_DESER_PARITY_EN
    logic          i_lane_par = 1'b0;
    logic          o_par_err;
`endif

    always #5 clk = ~clk;

    cordic_input_deserializer #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .i_clk       (clk),
        .i_async_rst (i_async_rst),
        .i_lane_vld  (i_lane_vld),
        .i_lane_sof  (i_lane_sof),
        .i_lane_data (i_lane_data),
        .i_err_clr   (i_err_clr),
`ifdef CORDIC_DESER_PARITY_EN
        .i_lane_par  (i_lane_par),
        .o_par_err   (o_par_err),
`endif
        .o_vld       (o_vld),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_frame_cnt (o_frame_cnt)
    );

    int n_asrt = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_vld  = 0;
    int vld_at[$];

    // Frame model: beats of the current frame are held in a queue.
    logic [LW-1:0] q[$];
    logic          m_vld, m_pois, m_par_err;
    logic [DW-1:0] m_data;
    logic [1:0]    m_err;
    logic [CW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] assemble();
        logic [NB*LW-1:0] w = '0;
        for (int i = 0; i < NB; i++) w[LW*(NB-1-i) +: LW] = q[i];
        return w[DW-1:0];
    endfunction

    function automatic logic [LW-1:0] beat_of(input logic [DW-1:0] word, input int i);
        logic [NB*LW-1:0] w = (NB*LW)'(word);
        return w[LW*(NB-1-i) +: LW];
    endfunction

    task automatic model_reset();
        q.delete();
        m_vld = 0; m_pois = 0; m_par_err = 0;
        m_data = '0; m_err = '0; m_cnt = '0;
    endtask

    task automatic check_all();
        chk("vld", 64'(o_vld), 64'(m_vld));
        chk("data", 64'(o_data), 64'(m_data));
        chk("busy", 64'(o_busy), 64'(q.size() != 0));
        chk("err", 64'(o_err), 64'(m_err));
        chk("frame_cnt", 64'(o_frame_cnt), 64'(m_cnt));
`ifdef CORDIC_DESER_PARITY_EN
        chk("par_err", 64'(o_par_err), 64'(m_par_err));
`endif
        if (o_vld === 1'b1) begin
            n_vld++;
            vld_at.push_back(cyc);
        end
    endtask

    task automatic step(input logic vld, input logic sof, input logic [LW-1:0] d,
                        input logic clr, input logic bad);
        logic [1:0] set = '0;
        i_lane_vld  = vld;
        i_lane_sof  = sof;
        i_lane_data = d;
        i_err_clr   = clr;
`ifdef CORDIC_DESER_PARITY_EN
        i_lane_par  = (^d) ^ bad;
`endif
        m_vld = 0;
        if (clr) begin
            m_err = '0;
            m_par_err = 0;
        end
        if (vld) begin
            if (sof) begin
                if (q.size() != 0) set[1] = 1'b1;
                q.delete();
                q.push_back(d);
                m_pois = bad;
            end else if (q.size() == 0) begin
                set[0] = 1'b1;
            end else begin
                q.push_back(d);
                m_pois = m_pois | bad;
            end
`ifdef CORDIC_DESER_PARITY_EN
            if (bad) m_par_err = 1;
`endif
            if (q.size() == NB) begin
`ifdef CORDIC_DESER_PARITY_EN
                if (!m_pois) begin
`else
                begin
`endif
                    m_data = assemble();
                    m_vld  = 1;
                    m_cnt  = m_cnt + 1'b1;
                end
                q.delete();
            end
        end
        m_err = m_err | set;
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [DW-1:0] w, input int gap, input int bad_idx);
        for (int i = 0; i < NB; i++) begin
            step(1'b1, i == 0, beat_of(w, i), 1'b0, i == bad_idx);
            if (i < NB - 1) idle(gap);
        end
    endtask

    task automatic do_reset();
        #2 i_async_rst = 1'b1;
        #1;
        i_lane_vld = 0; i_lane_sof = 0; i_lane_data = '0; i_err_clr = 0;
        model_reset();
        check_all();
        @(posedge clk);
        #1 i_async_rst = 1'b0;
    endtask

    initial begin
        int base;
        logic [DW-1:0] wa, wb;
        do_reset();

        base = n_vld;
        send(49'h1_0000_0000_0003, 0, -1);
        chk("t1_data", 64'(o_data), 64'h1_0000_0000_0003);
        chk("t1_cnt", 64'(o_frame_cnt), 64'd1);
        chk("t1_err", 64'(o_err), 64'd0);
        chk("t1_pulses", 64'(n_vld - base), 64'd1);
        idle(2);

        base = n_vld;
        send(49'h1_0000_0000_0003, 2, -1);
        idle(2);
        chk("t2_data", 64'(o_data), 64'h1_0000_0000_0003);
        chk("t2_pulses", 64'(n_vld - base), 64'd1);

        step(1'b1, 1'b0, 7'h55, 1'b0, 1'b0);
        chk("t3_orphan_err", 64'(o_err), 64'd1);
        step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        chk("t3_clr_err", 64'(o_err), 64'd0);
        step(1'b1, 1'b0, 7'h2A, 1'b1, 1'b0);
        chk("t3_set_wins", 64'(o_err), 64'd1);
        step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);

        do_reset();
        base = n_vld;
        wa = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, beat_of(wa, i), 1'b0, 1'b0);
        send(49'h0_0000_0000_007F, 0, -1);
        idle(1);
        chk("t4_err", 64'(o_err), 64'd2);
        chk("t4_data", 64'(o_data), 64'h0_0000_0000_007F);
        chk("t4_cnt", 64'(o_frame_cnt), 64'd1);
        chk("t4_pulses", 64'(n_vld - base), 64'd1);

        do_reset();
        vld_at.delete();
        wa = {$urandom, $urandom};
        wb = {$urandom, $urandom};
        send(wa, 0, -1);
        send(wb, 0, -1);
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, beat_of(wa, i), 1'b0, 1'b0);
        i_lane_vld = 1; i_lane_sof = 0; i_lane_data = beat_of(wa, 3);
        do_reset();
        chk("t5_rst_data", 64'(o_data), 64'd0);
        chk("t5_rst_cnt", 64'(o_frame_cnt), 64'd0);
        idle(10);
        chk("t5_pulses", 64'(vld_at.size()), 64'd2);
        chk("t5_spacing", 64'(vld_at.size() >= 2 ? vld_at[1] - vld_at[0] : -1), 64'd7);

`ifdef CORDIC_DESER_PARITY_EN
        do_reset();
        base = n_vld;
        send(wa, 0, 2);
        idle(1);
        chk("t6_par_err", 64'(o_par_err), 64'd1);
        chk("t6_pulses", 64'(n_vld - base), 64'd0);
        chk("t6_data", 64'(o_data), 64'd0);
        step(1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        send(wb, 0, -1);
        chk("t6_good_data", 64'(o_data), 64'(wb));
        chk("t6_good_cnt", 64'(o_frame_cnt), 64'd1);
`endif

        do_reset();
        base = n_vld;
        for (int i = 0; i < 600; i++) begin
            logic v, s, c, b;
            v = $urandom_range(0, 3) != 0;
            s = $urandom_range(0, 9) == 0;
            c = $urandom_range(0, 19) == 0;
`ifdef CORDIC_DESER_PARITY_EN
            b = $urandom_range(0, 39) == 0;
`else
            b = 1'b0;
`endif
            step(v, s, LW'($urandom), c, b);
        end
        chk("rand_some_frames", 64'(n_vld - base > 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
